// File: rtl/lisnoc_dma_wb_arbiter_if.sv
// Bus bundle between the DMA sub-engines, the round-robin arbiter and the tile Wishbone bus.
// The slave modport is the arbiter's view; the master modport is the requester/bus side.
interface lisnoc_dma_wb_arbiter_if #(
    parameter int ports = 3
);
    logic [32*ports-1:0] m_adr_i;
    logic [32*ports-1:0] m_dat_i;
    logic [4*ports-1:0]  m_sel_i;
    logic [3*ports-1:0]  m_cti_i;
    logic [2*ports-1:0]  m_bte_i;
    logic [ports-1:0]    m_cyc_i;
    logic [ports-1:0]    m_stb_i;
    logic [ports-1:0]    m_we_i;
    logic [31:0]         m_dat_o;
    logic [ports-1:0]    m_ack_o;
    logic [ports-1:0]    m_err_o;
    logic [ports-1:0]    grant;
    logic [31:0]         wb_adr_o;
    logic [31:0]         wb_dat_o;
    logic [3:0]          wb_sel_o;
    logic [2:0]          wb_cti_o;
    logic [1:0]          wb_bte_o;
    logic                wb_cyc_o;
    logic                wb_stb_o;
    logic                wb_we_o;
    logic [31:0]         wb_dat_i;
    logic                wb_ack_i;
    logic                wb_err_i;

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i, m_cyc_i, m_stb_i, m_we_i,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output m_dat_o, m_ack_o, m_err_o, grant,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o, wb_cyc_o, wb_stb_o, wb_we_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i, m_cyc_i, m_stb_i, m_we_i,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  m_dat_o, m_ack_o, m_err_o, grant,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o, wb_cyc_o, wb_stb_o, wb_we_o
    );
endinterface

// File: rtl/lisnoc_dma_wb_arbiter.sv
// Round-robin, cyc-locked Wishbone master arbiter for the DMA tile.
// Define LISNOC_DMA_WB_ARB_TIMEOUT_EN to add the stalled-slave watchdog and ABORT state.
module lisnoc_dma_wb_arbiter #(
    parameter int ports   = 3
`ifdef LISNOC_DMA_WB_ARB_TIMEOUT_EN
   ,parameter int timeout = 255
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    lisnoc_dma_wb_arbiter_if.slave    bus
);
    localparam int ptrwidth = $clog2(ports);

`ifdef LISNOC_DMA_WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ABORT = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;
`endif

    state_t              r_state;
    state_t              w_next_state;
    logic [ptrwidth-1:0] r_last_grant;
    logic [ptrwidth-1:0] w_next_owner;
    logic [ptrwidth:0]   w_idx;
    logic                w_found;
    logic [ports-1:0]    w_onehot;

    assign w_onehot = {{(ports-1){1'b0}}, 1'b1} << r_last_grant;

`ifdef LISNOC_DMA_WB_ARB_TIMEOUT_EN
    logic [15:0] r_timer;
    logic        w_owner_stb;
    logic        w_expire;

    assign w_owner_stb = bus.m_stb_i[r_last_grant];
    // ack or err in the expiry cycle wins over the abort
    assign w_expire = (r_state == GRANT) && w_owner_stb && !bus.wb_ack_i && !bus.wb_err_i
                      && (r_timer == 16'(timeout - 1));

    // Stall watchdog: counts consecutive unanswered strobe cycles of the owner
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= 16'd0;
        end else if ((r_state != GRANT) || !w_owner_stb || bus.wb_ack_i || bus.wb_err_i) begin
            r_timer <= 16'd0;
        end else begin
            r_timer <= r_timer + 16'd1;
        end
    end
`endif

    // Rotation search: first requester after the previous owner, wrapping
    always_comb begin
        w_found      = 1'b0;
        w_next_owner = r_last_grant;
        w_idx        = '0;
        for (int i = 1; i <= ports; i++) begin
            w_idx = {1'b0, r_last_grant} + (ptrwidth+1)'(i);
            if (w_idx >= (ptrwidth+1)'(ports)) begin
                w_idx = w_idx - (ptrwidth+1)'(ports);
            end else begin
                w_idx = w_idx;
            end
            if (!w_found && bus.m_cyc_i[w_idx[ptrwidth-1:0]]) begin
                w_found      = 1'b1;
                w_next_owner = w_idx[ptrwidth-1:0];
            end else begin
                w_found      = w_found;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_found) w_next_state = GRANT;
                else         w_next_state = IDLE;
            end
            GRANT: begin
                if (!bus.m_cyc_i[r_last_grant]) w_next_state = IDLE;
`ifdef LISNOC_DMA_WB_ARB_TIMEOUT_EN
                else if (w_expire)              w_next_state = ABORT;
`endif
                else                            w_next_state = GRANT;
            end
`ifdef LISNOC_DMA_WB_ARB_TIMEOUT_EN
            ABORT: begin
                if (!bus.m_cyc_i[r_last_grant]) w_next_state = IDLE;
                else                            w_next_state = ABORT;
            end
`endif
            default: w_next_state = IDLE;
        endcase
    end

    // State and rotation pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= ptrwidth'(ports - 1);
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && w_found) r_last_grant <= w_next_owner;
            else                              r_last_grant <= r_last_grant;
        end
    end

    // Bus and requester-side outputs, muxed from the registered owner
    always_comb begin
        bus.grant    = {ports{1'b0}};
        bus.m_ack_o  = {ports{1'b0}};
        bus.m_err_o  = {ports{1'b0}};
        bus.m_dat_o  = 32'd0;
        bus.wb_adr_o = 32'd0;
        bus.wb_dat_o = 32'd0;
        bus.wb_sel_o = 4'd0;
        bus.wb_cti_o = 3'd0;
        bus.wb_bte_o = 2'd0;
        bus.wb_cyc_o = 1'b0;
        bus.wb_stb_o = 1'b0;
        bus.wb_we_o  = 1'b0;
        case (r_state)
            GRANT: begin
                bus.grant    = w_onehot;
                bus.wb_adr_o = bus.m_adr_i[int'(r_last_grant)*32 +: 32];
                bus.wb_dat_o = bus.m_dat_i[int'(r_last_grant)*32 +: 32];
                bus.wb_sel_o = bus.m_sel_i[int'(r_last_grant)*4 +: 4];
                bus.wb_cti_o = bus.m_cti_i[int'(r_last_grant)*3 +: 3];
                bus.wb_bte_o = bus.m_bte_i[int'(r_last_grant)*2 +: 2];
                bus.wb_cyc_o = bus.m_cyc_i[r_last_grant];
                bus.wb_stb_o = bus.m_stb_i[r_last_grant];
                bus.wb_we_o  = bus.m_we_i[r_last_grant];
                bus.m_dat_o  = bus.wb_dat_i;
                bus.m_ack_o[r_last_grant] = bus.wb_ack_i;
`ifdef LISNOC_DMA_WB_ARB_TIMEOUT_EN
                bus.m_err_o[r_last_grant] = bus.wb_err_i | w_expire;
`else
                bus.m_err_o[r_last_grant] = bus.wb_err_i;
`endif
            end
`ifdef LISNOC_DMA_WB_ARB_TIMEOUT_EN
            ABORT: begin
                bus.grant = w_onehot;
            end
`endif
            default: begin
                bus.grant = {ports{1'b0}};
            end
        endcase
    end
endmodule

// File: tb/tb_lisnoc_dma_wb_arbiter.sv
// Directed self-checking bench for lisnoc_dma_wb_arbiter (3 ports).
// With LISNOC_DMA_WB_ARB_TIMEOUT_EN defined the watchdog scenario runs with timeout=8.
module tb_lisnoc_dma_wb_arbiter;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    lisnoc_dma_wb_arbiter_if #(.ports(3)) bus();

`ifdef LISNOC_DMA_WB_ARB_TIMEOUT_EN
    lisnoc_dma_wb_arbiter #(.ports(3), .timeout(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`else
    lisnoc_dma_wb_arbiter #(.ports(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        bus.m_adr_i  = {32'hC000_0020, 32'hB000_0010, 32'hA000_0000};
        bus.m_dat_i  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        bus.m_sel_i  = {4'hC, 4'h3, 4'hF};
        bus.m_cti_i  = {3'd7, 3'd2, 3'd0};
        bus.m_bte_i  = {2'd1, 2'd0, 2'd0};
        bus.m_cyc_i  = 3'b111;
        bus.m_stb_i  = 3'b000;
        bus.m_we_i   = 3'b010;
        bus.wb_dat_i = 32'hDEAD_BEEF;
        bus.wb_ack_i = 1'b1;
        bus.wb_err_i = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", bus.grant); end
        n_chk++; if (bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc: got %b want 0", bus.wb_cyc_o); end
        n_chk++; if (bus.wb_adr_o !== 32'h0) begin n_fail++; $display("FAIL reset_adr: got %h want 0", bus.wb_adr_o); end
        n_chk++; if (bus.m_ack_o !== 3'b000) begin n_fail++; $display("FAIL reset_ack: got %b want 000", bus.m_ack_o); end
        n_chk++; if (bus.m_err_o !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b want 000", bus.m_err_o); end
        n_chk++; if (bus.m_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", bus.m_dat_o); end
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        rst = 1'b1;
        #1;
        n_chk++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL release_latency: got %b want 000", bus.grant); end
        @(negedge clk);
        n_chk++; if (bus.grant !== 3'b001) begin n_fail++; $display("FAIL first_grant: got %b want 001", bus.grant); end
        n_chk++; if (bus.wb_adr_o !== 32'hA000_0000) begin n_fail++; $display("FAIL first_adr: got %h want a0000000", bus.wb_adr_o); end
        n_chk++; if (bus.wb_cyc_o !== 1'b1) begin n_fail++; $display("FAIL first_cyc: got %b want 1", bus.wb_cyc_o); end
        n_chk++; if (bus.wb_sel_o !== 4'hF) begin n_fail++; $display("FAIL first_sel: got %h want f", bus.wb_sel_o); end
        bus.m_stb_i  = 3'b111;
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h1234_5678;
        #1;
        n_chk++; if (bus.m_ack_o !== 3'b001) begin n_fail++; $display("FAIL first_ack: got %b want 001", bus.m_ack_o); end
        n_chk++; if (bus.m_dat_o !== 32'h1234_5678) begin n_fail++; $display("FAIL first_dat: got %h want 12345678", bus.m_dat_o); end
    endtask

    task automatic test_reads();
        logic [31:0] exp_dat;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            exp_dat = 32'h5000_0000 + 32'(n);
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = exp_dat;
            @(negedge clk);
            n_chk++; if (bus.m_ack_o !== 3'b001) begin n_fail++; $display("FAIL read_ack[%0d]: got %b want 001", n, bus.m_ack_o); end
            n_chk++; if (bus.m_dat_o !== exp_dat) begin n_fail++; $display("FAIL read_dat[%0d]: got %h want %h", n, bus.m_dat_o, exp_dat); end
            n_chk++; if (bus.grant !== 3'b001) begin n_fail++; $display("FAIL read_grant[%0d]: got %b want 001", n, bus.grant); end
        end
        @(posedge clk); #1;
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 32'hFFFF_0000;
        bus.m_cyc_i  = 3'b110;
        bus.m_stb_i  = 3'b110;
        @(negedge clk);
        n_chk++; if (bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL drop_cyc: got %b want 0", bus.wb_cyc_o); end
        @(negedge clk);
        n_chk++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL gap_grant: got %b want 000", bus.grant); end
        n_chk++; if (bus.m_dat_o !== 32'h0) begin n_fail++; $display("FAIL gap_dat: got %h want 0", bus.m_dat_o); end
        @(negedge clk);
        n_chk++; if (bus.grant !== 3'b010) begin n_fail++; $display("FAIL p1_grant: got %b want 010", bus.grant); end
        n_chk++; if (bus.wb_adr_o !== 32'hB000_0010) begin n_fail++; $display("FAIL p1_adr: got %h want b0000010", bus.wb_adr_o); end
        n_chk++; if (bus.wb_sel_o !== 4'h3) begin n_fail++; $display("FAIL p1_sel: got %h want 3", bus.wb_sel_o); end
        n_chk++; if (bus.wb_we_o !== 1'b1) begin n_fail++; $display("FAIL p1_we: got %b want 1", bus.wb_we_o); end
        n_chk++; if (bus.wb_cti_o !== 3'd2) begin n_fail++; $display("FAIL p1_cti: got %0d want 2", bus.wb_cti_o); end
        bus.m_cyc_i = 3'b100;
        bus.m_stb_i = 3'b100;
        @(negedge clk);
        n_chk++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL gap2_grant: got %b want 000", bus.grant); end
        @(negedge clk);
        n_chk++; if (bus.grant !== 3'b100) begin n_fail++; $display("FAIL p2_grant: got %b want 100", bus.grant); end
        n_chk++; if (bus.wb_adr_o !== 32'hC000_0020) begin n_fail++; $display("FAIL p2_adr: got %h want c0000020", bus.wb_adr_o); end
        bus.m_cyc_i = 3'b000;
        bus.m_stb_i = 3'b000;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL idle_grant: got %b want 000", bus.grant); end
    endtask

    task automatic test_fairness();
        logic [2:0] exp_g;
        bus.m_cyc_i = 3'b101;
        bus.m_stb_i = 3'b101;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 3'b001 : 3'b100;
            @(negedge clk);
            n_chk++; if (bus.grant !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, bus.grant, exp_g); end
            @(posedge clk); #1;
            bus.wb_ack_i = 1'b1;
            @(negedge clk);
            n_chk++; if (bus.m_ack_o !== exp_g) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b want %b", i, bus.m_ack_o, exp_g); end
            @(posedge clk); #1;
            bus.wb_ack_i = 1'b0;
            bus.m_cyc_i  = 3'b101 & ~exp_g;
            @(negedge clk);
            @(negedge clk);
            n_chk++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL rr_gap[%0d]: got %b want 000", i, bus.grant); end
            bus.m_cyc_i = 3'b101;
        end
        bus.m_cyc_i = 3'b000;
        bus.m_stb_i = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_err();
        bus.m_cyc_i = 3'b010;
        bus.m_stb_i = 3'b010;
        @(negedge clk);
        n_chk++; if (bus.grant !== 3'b010) begin n_fail++; $display("FAIL err_grant: got %b want 010", bus.grant); end
        @(posedge clk); #1;
        bus.wb_err_i = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.m_err_o !== 3'b010) begin n_fail++; $display("FAIL err_pulse: got %b want 010", bus.m_err_o); end
        n_chk++; if (bus.m_ack_o !== 3'b000) begin n_fail++; $display("FAIL err_noack: got %b want 000", bus.m_ack_o); end
        @(posedge clk); #1;
        bus.wb_err_i = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.m_err_o !== 3'b000) begin n_fail++; $display("FAIL err_clear: got %b want 000", bus.m_err_o); end
        n_chk++; if (bus.grant !== 3'b010) begin n_fail++; $display("FAIL err_owner: got %b want 010", bus.grant); end
    endtask

    task automatic test_relock();
        bus.m_cyc_i = 3'b000;
        @(negedge clk);
        @(negedge clk);
        bus.m_cyc_i = 3'b010;
        @(negedge clk);
        n_chk++; if (bus.grant !== 3'b010) begin n_fail++; $display("FAIL relock_alone: got %b want 010", bus.grant); end
        bus.m_cyc_i = 3'b001;
        @(negedge clk);
        bus.m_cyc_i = 3'b011;
        @(negedge clk);
        n_chk++; if (bus.grant !== 3'b001) begin n_fail++; $display("FAIL relock_yield: got %b want 001", bus.grant); end
        bus.m_cyc_i = 3'b010;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (bus.grant !== 3'b010) begin n_fail++; $display("FAIL relock_p1: got %b want 010", bus.grant); end
    endtask

    task automatic test_midreset();
        bus.m_stb_i = 3'b010;
        #1;
        n_chk++; if (bus.wb_stb_o !== 1'b1) begin n_fail++; $display("FAIL mid_stb_pre: got %b want 1", bus.wb_stb_o); end
        #1;
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'hCAFE_F00D;
        rst = 1'b0;
        #1;
        n_chk++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL mid_grant: got %b want 000", bus.grant); end
        n_chk++; if (bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL mid_cyc: got %b want 0", bus.wb_cyc_o); end
        n_chk++; if (bus.wb_stb_o !== 1'b0) begin n_fail++; $display("FAIL mid_stb: got %b want 0", bus.wb_stb_o); end
        n_chk++; if (bus.m_ack_o !== 3'b000) begin n_fail++; $display("FAIL mid_ack: got %b want 000", bus.m_ack_o); end
        n_chk++; if (bus.m_dat_o !== 32'h0) begin n_fail++; $display("FAIL mid_dat: got %h want 0", bus.m_dat_o); end
        bus.wb_ack_i = 1'b0;
        bus.m_cyc_i  = 3'b111;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.grant !== 3'b001) begin n_fail++; $display("FAIL mid_restart: got %b want 001", bus.grant); end
    endtask

`ifdef LISNOC_DMA_WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bus.m_cyc_i  = 3'b100;
        bus.m_stb_i  = 3'b100;
        bus.wb_ack_i = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_chk++; if (bus.m_err_o !== ((c == 8) ? 3'b100 : 3'b000)) begin n_fail++; $display("FAIL tmo_err[%0d]: got %b", c, bus.m_err_o); end
        end
        @(negedge clk);
        n_chk++; if (bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL abort_cyc: got %b want 0", bus.wb_cyc_o); end
        n_chk++; if (bus.grant !== 3'b100) begin n_fail++; $display("FAIL abort_grant: got %b want 100", bus.grant); end
        n_chk++; if (bus.m_err_o !== 3'b000) begin n_fail++; $display("FAIL abort_err: got %b want 000", bus.m_err_o); end
        bus.m_cyc_i = 3'b000;
        @(negedge clk);
        n_chk++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL abort_exit: got %b want 000", bus.grant); end
        bus.m_cyc_i = 3'b100;
        @(negedge clk);
        for (int c = 2; c <= 8; c++) begin
            @(posedge clk); #1;
            bus.wb_ack_i = (c == 8);
            @(negedge clk);
        end
        n_chk++; if (bus.m_ack_o !== 3'b100) begin n_fail++; $display("FAIL tmo_ack: got %b want 100", bus.m_ack_o); end
        n_chk++; if (bus.m_err_o !== 3'b000) begin n_fail++; $display("FAIL tmo_ack_err: got %b want 000", bus.m_err_o); end
        @(posedge clk); #1;
        bus.wb_ack_i = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.wb_cyc_o !== 1'b1) begin n_fail++; $display("FAIL tmo_noabort: got %b want 1", bus.wb_cyc_o); end
    endtask
`endif

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_reads();
        test_fairness();
        test_err();
        test_relock();
        test_midreset();
`ifdef LISNOC_DMA_WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lisnoc_dma_wb_arbiter.md
Name: lisnoc_dma_wb_arbiter

Overview:
Round-robin Wishbone master arbiter that shares the DMA tile's single Wishbone master bus between N internal requesters: initiator-request, initiator-response, target and future engines. Replaces fixed-priority muxing with fair, lock-preserving arbitration. Optionally runs a stalled-slave watchdog that aborts hung cycles. Sits between the DMA sub-engines and the tile's memory bus.

Parameters:
ports, 3, number of requesting masters (2..8)
ptrwidth, $clog2(ports), grant pointer width (localparam)
timeout, 255, max stb cycles without ack/err before abort (only with LISNOC_DMA_WB_ARB_TIMEOUT_EN; 1..65535)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
m_adr_i  in  32*ports  per-master address, master k at [32k+31:32k]
m_dat_i  in  32*ports  per-master write data
m_sel_i  in  4*ports  per-master byte select
m_cti_i  in  3*ports  per-master cycle type
m_bte_i  in  2*ports  per-master burst type
m_cyc_i  in  ports  per-master cyc (bus request)
m_stb_i  in  ports  per-master stb
m_we_i  in  ports  per-master write enable
m_dat_o  out  32  read data, common to all masters; valid only for owner
m_ack_o  out  ports  per-master ack
m_err_o  out  ports  per-master err
grant  out  ports  one-hot current owner, 0 when idle
wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o  out  32/32/4/3/2  bus master outputs
wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  bus master outputs
wb_dat_i  in  32  bus read data
wb_ack_i  in  1  bus ack
wb_err_i  in  1  bus err

Behaviour:
- FSM states: IDLE, GRANT, ABORT (ABORT exists only with the macro). State and last_grant are registered.
- Reset (async, rst=0): state=IDLE, last_grant=ports-1, grant=0, timer=0. All wb_* outputs 0. m_ack_o=0, m_err_o=0, m_dat_o=0, applied immediately, including mid-transfer.
- IDLE: bus outputs all 0, grant=0. If any m_cyc_i is high at the edge, go to GRANT.
  - Owner = first k with m_cyc_i[k]=1, searching last_grant+1, +2, ... with wrap modulo ports.
  - last_grant <= owner.
- Latency: a request seen in IDLE gets its grant on the next cycle. The bus shows owner signals from that cycle on.
- GRANT: wb_* = owner's signals (combinational mux from registered owner).
  - m_ack_o[owner]=wb_ack_i, m_err_o[owner]=wb_err_i, m_dat_o=wb_dat_i.
  - Non-owners: ack=0, err=0.
  - Owner holds the bus for as long as its m_cyc_i stays 1. Burst/cti is not inspected; locking follows cyc.
  - When the owner's m_cyc_i=0 at an edge, go to IDLE. This gives at least one bus-idle cycle between owners.
- Non-owner cyc/stb is ignored. Requesters simply wait, with no starvation: each waits at most ports-1 tenures.
- Simultaneous requests in IDLE: rotation order decides.
- An owner dropping cyc while others request: IDLE for 1 cycle, then the next requester in rotation is granted.
- Owner requesting again immediately after release: it is granted only if no other port is requesting.
- m_dat_o outside GRANT: 0.

Optional Feature:
LISNOC_DMA_WB_ARB_TIMEOUT_EN
- With the macro:
  - A 16-bit timer clears on grant, on wb_ack_i, on wb_err_i, or when wb_stb_o=0.
  - It increments each GRANT cycle with wb_stb_o=1 and no ack/err.
  - When timer==timeout: m_err_o[owner]=1 for exactly that cycle, and the next state is ABORT.
  - ABORT: wb_cyc_o=wb_stb_o=0, grant stays on the owner, acks are 0. Leave to IDLE when the owner drops m_cyc_i.
  - A wb_ack_i arriving in the same cycle as expiry wins: ack is delivered, no err, no abort.
- Without the macro: no timer, no ABORT state; err is a pure pass-through; a hung slave hangs the bus.

Test Plan:
- Reset with m_cyc_i=3'b111 held, release rst -> port 0 is granted 1 cycle later (grant=001). Bus shows m_adr_i[31:0]. Other ports get ack=0.
- Port 0 does 4 single reads with wb_ack_i each, then drops cyc, ports 1,2 requesting -> 1 IDLE cycle, grant=010; then after port 1 releases, grant=100.
- Ports 0 and 2 request forever, each releasing after 1 ack -> grant sequence 001,100,001,100 with an IDLE cycle between each; port 1 never granted.
- Port 1 write with wb_err_i pulsed -> m_err_o=010 for 1 cycle, m_ack_o=000, owner unchanged until cyc drops.
- With macro and timeout=8: port 2 stb held, no ack -> m_err_o[2]=1 on the 8th stalled cycle, wb_cyc_o=0 the next cycle, IDLE after port 2 drops cyc. Repeat with ack on cycle 8 -> ack only, no err.
- Assert rst mid-burst (owner=1, wb_stb_o=1) -> all outputs 0 asynchronously; after release, port 0 is first in rotation.
